// File: rtl/ip_pkg.sv
// Shared types and default sizing for the multi-channel ingest block.
// Holds the processing-mode enum and the default parameter values.
package ip_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_THR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts after last_grant.
// Ports: req (requests), en (allow grant), last_grant, grant (one-hot/0).
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic           en,
    input  logic [SW-1:0]  last_grant,
    output logic [NCH-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            // wrap the candidate index without a modulo operator
            idx = int'(last_grant) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_multi_ch.sv
// Multi-channel ingest: round-robin accept, per-word processing, FWFT FIFO.
// Ports: req_* (channel inputs), mode/thresh, out_* (FIFO head), fifo_* status.
module ip_multi_ch
    import ip_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int NCH   = DEF_NCH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int SW    = $clog2(NCH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     thresh,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SW-1:0]     out_src,
    input  logic              out_ready,
    output logic [SW:0]       mstr_data_valid,
    output logic [CW-1:0]     fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    last_grant;
    logic [SW-1:0]    grant_idx;
    logic [NCH-1:0]   grant;
    logic [DW-1:0]    sel_data;
    logic [DW-1:0]    proc_data;
    logic [SW+DW-1:0] head;
    logic             push;
    logic             pop;

    logic [SW+DW-1:0] mem [DEPTH];

    // reset also masks grants so nothing is accepted during reset
    rr_arbiter #(.NCH(NCH)) u_arb (
        .req        (req_valid),
        .en         (!fifo_full && !rst),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign push      = |grant;
    assign pop       = !fifo_empty && out_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) grant_idx = SW'(i);
        end
    end

    assign sel_data = req_data[grant_idx*DW +: DW];

    always_comb begin
        case (mode_e'(mode))
            MODE_INV: proc_data = ~sel_data;
            MODE_THR: proc_data = {DW{sel_data >= thresh}};
            default:  proc_data = sel_data;
        endcase
    end

    // storage array is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant_idx, proc_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= SW'(NCH - 1);
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant_idx;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_count = count;
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign out_valid  = !fifo_empty;

    assign head     = mem[rd_ptr];
    assign out_data = fifo_empty ? '0 : head[DW-1:0];
    assign out_src  = fifo_empty ? '0 : head[SW+DW-1:DW];

    assign mstr_data_valid = {out_src, out_valid};

endmodule

// File: tb/tb_ip_multi_ch.sv
// Directed bench for ip_multi_ch with hand-computed expectations.
// Covers reset, arbitration order, modes, full/pop, wrap, mid-run reset.
module tb_ip_multi_ch;

    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int SW    = 2;
    localparam int CW    = 5;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [1:0]        mode;
    logic [DW-1:0]     thresh;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready;
    logic [SW:0]       mstr_data_valid;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    int n_chk;
    int n_pass;
    logic [31:0] q[$];

    ip_multi_ch #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .mode            (mode),
        .thresh          (thresh),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_src         (out_src),
        .out_ready       (out_ready),
        .mstr_data_valid (mstr_data_valid),
        .fifo_count      (fifo_count),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        req_data[ch*DW +: DW] = v;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        mode      = 2'd0;
        thresh    = '0;
        out_ready = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        step();
        step();
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mdv", mstr_data_valid, 0);
        check("rst_data", out_data, 0);

        // round-robin with all channels valid, streaming out
        rst       = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'h100 + i);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", req_ready, 64'(1 << (k % 4)));
            step();
            check("rr_src", out_src, k % 4);
            check("rr_data", out_data, 32'h100 + (k % 4));
            check("rr_count", fifo_count, 1);
            if (k == 0) check("rr_mdv0", mstr_data_valid, 1);
        end
        req_valid = '0;
        step();
        check("rr_drain", fifo_empty, 1);

        // single accept into an empty FIFO
        out_ready = 1'b0;
        req_valid = 4'b0100;
        set_ch(2, 32'hABC);
        #1;
        check("one_pre", out_valid, 0);
        step();
        req_valid = '0;
        check("one_valid", out_valid, 1);
        check("one_mdv", mstr_data_valid, 3'b101);
        check("one_data", out_data, 32'hABC);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("one_pop", fifo_empty, 1);

        // fill to full on channel 1
        req_valid = 4'b0010;
        for (int i = 0; i < DEPTH; i++) begin
            set_ch(1, 32'h200 + i);
            #1;
            if (i == 0) check("fill_ready", req_ready, 4'b0010);
            step();
        end
        check("full_flag", fifo_full, 1);
        check("full_count", fifo_count, 16);
        check("full_ready", req_ready, 0);
        check("full_head", out_data, 32'h200);
        out_ready = 1'b1;
        set_ch(1, 32'h2FF);
        #1;
        check("full_nobyp", req_ready, 0);
        step();
        check("pop_count", fifo_count, 15);
        check("pop_head", out_data, 32'h201);
        out_ready = 1'b0;
        #1;
        check("pop_ready", req_ready, 4'b0010);
        step();
        check("refill", fifo_count, 16);
        req_valid = '0;
        out_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            #1;
            check("drain", out_data, (j < 15) ? 32'h201 + j : 32'h2FF);
            step();
        end
        check("drain_empty", fifo_empty, 1);
        out_ready = 1'b0;

        // processing modes on channel 0
        thresh    = 32'h80;
        req_valid = 4'b0001;
        mode      = 2'd2;
        set_ch(0, 32'h7F);
        step();
        set_ch(0, 32'h80);
        step();
        mode = 2'd1;
        set_ch(0, 32'h0000FFFF);
        step();
        mode = 2'd3;
        set_ch(0, 32'h12345678);
        step();
        req_valid = '0;
        mode      = 2'd0;
        check("mode_cnt", fifo_count, 4);
        check("thr_lo", out_data, 32'h0);
        out_ready = 1'b1;
        step();
        check("thr_hi", out_data, 32'hFFFFFFFF);
        step();
        check("inv", out_data, 32'hFFFF0000);
        step();
        check("rsvd", out_data, 32'h12345678);
        step();
        check("mode_empty", fifo_empty, 1);
        check("empty_src", out_src, 0);

        // steady push+pop with pointer wrap
        out_ready = 1'b0;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            set_ch(1, 32'h400 + i);
            q.push_back(32'h400 + i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            set_ch(1, 32'h500 + i);
            #1;
            check("wrap_data", out_data, q[0]);
            step();
            check("wrap_count", fifo_count, 5);
            void'(q.pop_front());
            q.push_back(32'h500 + i);
        end

        // reset with nine entries stored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_cnt", fifo_count, 9);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        check("rst2_ready", req_ready, 0);
        step();
        check("rst2_count", fifo_count, 0);
        check("rst2_valid", out_valid, 0);
        check("rst2_mdv", mstr_data_valid, 0);
        check("rst2_empty", fifo_empty, 1);
        rst = 1'b0;
        #1;
        check("rst2_grant", req_ready, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ip_multi_ch.md
IP_MULTI_CH -- requirements
Module: ip_multi_ch

Interface
REQ-001 Parameter DW, default 32: data word width in bits.
REQ-002 Parameter NCH, default 4: number of requester channels, range 2..16.
REQ-003 Parameter DEPTH, default 16: FIFO entries, a power of two, minimum 4.
REQ-004 Derived widths: SW = $clog2(NCH); CW = $clog2(DEPTH+1).
REQ-005 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, NCH bits: per-channel word valid.
REQ-008 Port req_data, input, NCH*DW bits: channel i occupies bits [i*DW +: DW].
REQ-009 Port req_ready, output, NCH bits: per-channel accept, one-hot or zero.
REQ-010 Port mode, input, 2 bits: processing operation.
REQ-011 Port thresh, input, DW bits: threshold value for mode 2.
REQ-012 Port out_valid, output, 1 bit: FIFO head is valid.
REQ-013 Port out_data, output, DW bits: processed word at the FIFO head.
REQ-014 Port out_src, output, SW bits: channel index of the head word.
REQ-015 Port out_ready, input, 1 bit: consumer accepts the head word.
REQ-016 Port mstr_data_valid, output, SW+1 bits: equals {out_src, out_valid}.
REQ-017 Ports fifo_count (CW bits), fifo_full (1 bit) and fifo_empty (1 bit), all outputs: occupancy status.

Function
REQ-018 Arbitration: when fifo_full=0, exactly one requesting channel is granted per cycle; when fifo_full=1, req_ready is all zeros.
REQ-019 Round-robin order: the search starts at (last_grant+1) mod NCH; last_grant updates only on an accepted transfer.
REQ-020 req_ready is combinational from req_valid, fifo_full and last_grant; req_ready[i]=1 implies req_valid[i]=1.
REQ-021 A transfer occurs when req_valid[i] & req_ready[i]; the word is processed and pushed into the FIFO in the same cycle.
REQ-022 Processing, using mode sampled at the accept cycle:
- mode 0: data passes through unchanged.
- mode 1: data is inverted (~data).
- mode 2: output is all-ones if data >= thresh (unsigned), otherwise zero.
- mode 3: reserved; behaves as mode 0.
REQ-023 Each FIFO entry stores {src, processed data}, i.e. SW+DW bits.
REQ-024 The FIFO is first-word-fall-through: a word accepted in cycle t is visible on out_* in cycle t+1 when the FIFO was empty.
REQ-025 out_valid = !fifo_empty; when the FIFO is empty, out_data and out_src are 0.
REQ-026 A pop occurs when out_valid & out_ready; out_ready while empty has no effect.
REQ-027 A simultaneous push and pop leaves fifo_count unchanged and advances both pointers.
REQ-028 There is no full bypass: at fifo_full=1 no push occurs, even if a pop occurs in the same cycle.
REQ-029 Read and write pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH; fifo_full = (count==DEPTH); fifo_empty = (count==0).
REQ-030 FIFO order is preserved across channels: output order equals accept order.

Reset
REQ-031 While rst=1 at a clock edge:
- pointers and count are set to 0 and last_grant is set to NCH-1, so channel 0 has first priority;
- all outputs read 0, except fifo_empty=1;
- req_ready=0.
REQ-032 Reset mid-operation discards all stored words; the memory array itself is not reset.

Structure
REQ-033 Package ip_pkg holds the mode enum (MODE_PASS, MODE_INV, MODE_THR, MODE_RSVD) and the default DW, NCH and DEPTH constants.
REQ-034 The round-robin grant logic is a separate sub-module, rr_arbiter, parameterised by NCH, with ports req, en, grant and last_grant.

Verification
REQ-035 Reset, then all channels valid with mode 0 and out_ready=1 → grants in order 0,1,2,3,0; out_src sequence is 0,1,2,3; data unchanged.
REQ-036 out_ready=0 and channel 1 streaming → fifo_full after 16 accepts, fifo_count=16, req_ready=0; one pop → count=15, no same-cycle push, push on the next cycle.
REQ-037 Mode 2, thresh=0x80, inputs 0x7F and 0x80 → out_data 0x00000000 then 0xFFFFFFFF; mode 1 with input 0x0000FFFF → 0xFFFF0000.
REQ-038 Push and pop every cycle for 40 cycles → count held constant, pointers wrap, order preserved.
REQ-039 rst asserted with count=9 → next cycle count=0, out_valid=0, mstr_data_valid=0; next grant goes to channel 0.
REQ-040 Empty FIFO, single accept at cycle t → out_valid=1 at t+1 with mstr_data_valid={src,1'b1}.
